// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encodings (also used by the register-file
// slave) and the default widths of the requester-side master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the previous
// winner and wraps modulo NUM_REQ; outputs a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one slave among NUM_REQ requesters.
// Optional ACCESS timeout with err flag: define APB_MASTER_TIMEOUT_EN.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           err,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH-1:0]          PRDATA,
  input  logic                           PREADY
);

  localparam int IDX_W = $clog2(NUM_REQ);

  apb_state_e         state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] eligible;

  // A requester that has just been acked may still hold req for one cycle.
  assign eligible = req & ~ack;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (eligible),
    .last  (last),
    .grant (pick_oh),
    .idx   (pick_idx)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state   <= IDLE;
      last    <= IDX_W'(NUM_REQ - 1);
      win_oh  <= '0;
      ack     <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            last    <= pick_idx;
            win_oh  <= pick_oh;
            PWRITE  <= req_write[pick_idx];
            PADDR   <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            PWDATA  <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            PSEL    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            if (!PWRITE) rdata <= PRDATA;
            ack     <= win_oh;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          // This low cycle is the TIMEOUT_CYCLES-th one: abandon the transfer.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rdata   <= '0;
            err     <= 1'b1;
            ack     <= win_oh;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: behavioural APB slave with wait-state
// control, auto-dropping requesters and an ack scoreboard.
module tb_apb_rr_master;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic [NR-1:0]    req, req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    ack;
  logic [DW-1:0]    rdata;
  logic             err;
  logic [AW-1:0]    PADDR;
  logic             PSEL, PENABLE, PWRITE;
  logic [DW-1:0]    PWDATA, PRDATA;
  logic             PREADY;

  apb_rr_master #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(15)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .err(err), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 257) ^ 16'h5A5A;
  endfunction

  // Behavioural slave: wait_states low PREADY cycles per ACCESS, or stuck low.
  logic [DW-1:0] mem [256];
  bit            mem_ready = 1'b0;
  int            ws = 0;
  int            wait_states = 0;
  bit            stuck_low = 1'b0;

  assign PRDATA = mem[PADDR];
  assign PREADY = stuck_low ? 1'b0 : (ws >= wait_states);

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (!mem_ready) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
      mem_ready <= 1'b1;
    end else if (PSEL && PENABLE && PREADY && PWRITE) begin
      mem[PADDR] <= PWDATA;
    end
    if (PSEL && PENABLE && !PREADY) ws <= ws + 1;
    else ws <= 0;
  end

  // Scoreboard: expected completions in grant order.
  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [256];
  logic [DW-1:0] exp_hold = '0;

  function automatic void push_exp(input int id, input bit wr, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d, input bit e);
    exp_t x;
    x.id  = id;
    x.err = e;
    if (e) exp_hold = '0;
    else if (wr) model[a] = d;
    else exp_hold = model[a];
    x.rdata = exp_hold;
    sb.push_back(x);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn && ack != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", ack, 0);
        end else begin
          e = sb.pop_front();
          check("sb_ack", ack, NR'(1) << e.id);
          check("sb_rdata", rdata, e.rdata);
          check("sb_err", err, e.err);
        end
      end
    end
  end

  // Requesters drop req one cycle after seeing their ack unless held (sticky).
  logic [NR-1:0] sticky = '0;
  logic [NR-1:0] ack_seen = '0;

  initial begin
    forever begin
      @(negedge PCLK);
      for (int i = 0; i < NR; i++) begin
        if (ack_seen[i]) begin
          req[i]      = 1'b0;
          ack_seen[i] = 1'b0;
        end
        if (ack[i] && !sticky[i]) ack_seen[i] = 1'b1;
      end
    end
  end

  task automatic post(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[id]          = wr;
    req_addr[id*AW +: AW]  = a;
    req_wdata[id*DW +: DW] = d;
    req[id]                = 1'b1;
  endtask

  task automatic wait_ack(input int id, input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
    end while (!ack[id] && lat < budget);
    if (!ack[id]) check("ack_arrived", ack[id], 1);
  endtask

  task automatic settle();
    int t = 0;
    while ((req != '0 || PSEL || sb.size() != 0) && t < 50) begin
      @(negedge PCLK);
      t++;
    end
    check("settle_sb_empty", sb.size(), 0);
    repeat (2) @(negedge PCLK);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_psel"}, PSEL, 0);
    check({tag, "_penable"}, PENABLE, 0);
    check({tag, "_pwrite"}, PWRITE, 0);
    check({tag, "_paddr"}, PADDR, 0);
    check({tag, "_pwdata"}, PWDATA, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int last_cyc;
    int order [5] = '{0, 1, 2, 3, 0};

    for (int a = 0; a < 256; a++) model[a] = init_val(a);
    PRESETn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_idle_outputs("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Fairness: all four held; grants 0,1,2,3,0 three cycles apart.
    sticky = '1;
    for (int i = 0; i < NR; i++) post(i, 1'b0, AW'(8'h10 + i), '0);
    for (int k = 0; k < 5; k++) push_exp(order[k], 1'b0, AW'(8'h10 + order[k]), '0, 1'b0);
    seen = 0;
    last_cyc = 0;
    for (int t = 0; t < 40 && seen < 5; t++) begin
      @(negedge PCLK);
      if (ack != '0) begin
        check("fair_grant", ack, NR'(1) << order[seen]);
        if (seen > 0) check("fair_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        seen++;
        if (seen == 5) begin
          sticky = '0;
          req    = '0;
        end
      end
    end
    check("fair_count", seen, 5);
    settle();

    // Single write then read-back from requester 0.
    post(0, 1'b1, 8'h05, 16'hBEEF);
    push_exp(0, 1'b1, 8'h05, 16'hBEEF, 1'b0);
    @(negedge PCLK);
    check("wr_setup_psel", {PSEL, PENABLE}, 2'b10);
    check("wr_setup_pwrite", PWRITE, 1);
    check("wr_setup_paddr", PADDR, 8'h05);
    check("wr_setup_pwdata", PWDATA, 16'hBEEF);
    @(negedge PCLK);
    check("wr_access_psel", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    check("wr_done_psel", {PSEL, PENABLE}, 2'b00);
    check("wr_done_ack", ack, 4'b0001);
    settle();
    post(0, 1'b0, 8'h05, '0);
    push_exp(0, 1'b0, 8'h05, '0, 1'b0);
    wait_ack(0, 20, lat);
    check("rd_latency", lat, 3);
    check("rd_data", rdata, 16'hBEEF);
    settle();

    // Ack masking: requester 1 drops late while requester 2 is pending.
    post(1, 1'b0, 8'h11, '0);
    post(2, 1'b1, 8'h12, 16'hA5A5);
    push_exp(1, 1'b0, 8'h11, '0, 1'b0);
    push_exp(2, 1'b1, 8'h12, 16'hA5A5, 1'b0);
    wait_ack(1, 20, lat);
    check("mask_first_latency", lat, 3);
    @(negedge PCLK);
    check("mask_next_psel", PSEL, 1);
    check("mask_next_paddr", PADDR, 8'h12);
    wait_ack(2, 20, lat);
    check("mask_second_latency", lat, 2);
    settle();

    // Wait states: PREADY low for four ACCESS cycles.
    wait_states = 4;
    post(1, 1'b1, 8'h22, 16'h1234);
    push_exp(1, 1'b1, 8'h22, 16'h1234, 1'b0);
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
      if (lat >= 2 && !ack[1]) begin
        check("ws_paddr_stable", PADDR, 8'h22);
        check("ws_pwdata_stable", PWDATA, 16'h1234);
        check("ws_penable", PENABLE, 1);
      end
    end while (!ack[1] && lat < 30);
    check("ws_latency", lat, 7);
    wait_states = 0;
    settle();
    post(1, 1'b0, 8'h22, '0);
    push_exp(1, 1'b0, 8'h22, '0, 1'b0);
    wait_ack(1, 20, lat);
    check("ws_readback_latency", lat, 3);
    settle();

    // Reset during ACCESS: bus drops, no ack, requester 0 wins afterwards.
    wait_states = 10;
    post(0, 1'b0, 8'h05, '0);
    post(2, 1'b1, 8'h30, 16'h7777);
    repeat (2) @(negedge PCLK);
    check("rst_pre_access", {PSEL, PENABLE}, 2'b11);
    check("rst_pre_paddr", PADDR, 8'h30);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check_idle_outputs("rst_mid");
    PRESETn = 1'b1;
    wait_states = 0;
    exp_hold = '0;
    push_exp(0, 1'b0, 8'h05, '0, 1'b0);
    push_exp(2, 1'b1, 8'h30, 16'h7777, 1'b0);
    @(negedge PCLK);
    check("rst_next_psel", PSEL, 1);
    check("rst_next_paddr", PADDR, 8'h05);
    settle();

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout: PREADY stuck low ends the transfer with err and zero rdata.
    stuck_low = 1'b1;
    post(3, 1'b0, 8'h10, '0);
    push_exp(3, 1'b0, 8'h10, '0, 1'b1);
    wait_ack(3, 40, lat);
    check("to_latency", lat, 17);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
    stuck_low = 1'b0;
    settle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
